// File: rtl/axi_probe_target.sv
// axi_probe_target: AXI-lite responder with a small word-addressed memory, OKAY in range, SLVERR outside.
// Optional PROBE_TARGET_STALL_EN adds LFSR-driven ready stalls on AW, W and AR.
module axi_probe_target #(
  parameter int          DEPTH      = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        m_aresetn,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [7:0]  err_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  function automatic logic hit(input logic [31:0] a);
    return a >= BASE_ADDR && (a - BASE_ADDR) < 32'(DEPTH * 4);
  endfunction
  logic [31:0] mem [DEPTH];
  logic        aw_held, w_held;
  logic [31:0] aw_addr, w_data;
  logic [3:0]  w_strb;
  logic [2:0]  stall;
  r_state_t    state, state_d;
  logic        aw_hs, w_hs, ar_hs, commit, b_err, r_err;
  logic [8:0]  err_sum;
`ifdef PROBE_TARGET_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge m_aresetn)
    if (!m_aresetn) lfsr <= STALL_SEED;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign stall = lfsr[2:0];
`else
  assign stall = 3'b000;
`endif
  assign s_axi_awready = !aw_held && !stall[0];
  assign s_axi_wready  = !w_held && !stall[1];
  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign commit = aw_held && w_held && !s_axi_bvalid;
  assign b_err  = commit && !hit(aw_addr);
  assign r_err  = ar_hs && !hit(s_axi_araddr);
  assign err_sum = {1'b0, err_count} + 9'(b_err) + 9'(r_err);
  always_ff @(posedge clk or negedge m_aresetn)
    if (!m_aresetn) state <= R_IDLE;
    else state <= state_d;
  always_comb
    state_d = state == R_IDLE ? (ar_hs ? R_RESP : R_IDLE)
                              : (s_axi_rready ? R_IDLE : R_RESP);
  always_comb begin
    s_axi_arready = state == R_IDLE && !stall[2];
    s_axi_rvalid  = state == R_RESP;
  end
  always_ff @(posedge clk or negedge m_aresetn)
    if (!m_aresetn) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp <= 2'b00;
      s_axi_rdata <= '0;
      s_axi_rresp <= 2'b00;
      err_count <= '0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= s_axi_awaddr;
      end else if (commit) aw_held <= 1'b0;
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end else if (commit) w_held <= 1'b0;
      if (commit) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp <= b_err ? 2'b10 : 2'b00;
      end else if (s_axi_bready) s_axi_bvalid <= 1'b0;
      if (ar_hs) begin
        s_axi_rdata <= r_err ? 32'h0 : mem[s_axi_araddr[AW+1:2]];
        s_axi_rresp <= r_err ? 2'b10 : 2'b00;
      end
      err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  // Memory is deliberately left unreset; non-blocking update gives reads the pre-write word.
  always_ff @(posedge clk)
    if (commit && !b_err)
      for (int i = 0; i < 4; i++)
        if (w_strb[i]) mem[aw_addr[AW+1:2]][8*i+:8] <= w_data[8*i+:8];
endmodule
